// File: rtl/compute_arbiter.sv
// compute_arbiter: grants one of NUM_REQ processing units access to the single
// shared compute unit, runs the request/ready handshake, holds the grant until
// the unit reports done or a watchdog aborts the wait, and keeps utilisation
// counters for the system controller.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_enable          arbitration enable (gates new grants in IDLE only)
//   i_rr_mode         1 = round-robin, 0 = fixed priority (lowest index wins)
//   i_req             per-unit level-held compute request
//   o_grant           one-hot grant (registered)
//   o_grant_id        index of the granted unit
//   o_grant_valid     a grant is outstanding
//   o_cu_request      request to the shared compute unit
//   i_cu_ready        shared unit accepts the request
//   i_cu_done         shared unit finished the current operation
//   o_timeout_err     sticky watchdog flag
//   i_err_clr         clears o_timeout_err and both counters
//   o_busy_cycles     saturating count of non-IDLE cycles
//   o_txn_count       saturating count of completed transactions
module compute_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned ID_W           = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned COUNT_W        = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_enable,
    input  logic               i_rr_mode,
    input  logic [NUM_REQ-1:0] i_req,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_grant_id,
    output logic               o_grant_valid,
    output logic               o_cu_request,
    input  logic               i_cu_ready,
    input  logic               i_cu_done,
    output logic               o_timeout_err,
    input  logic               i_err_clr,
    output logic [COUNT_W-1:0] o_busy_cycles,
    output logic [COUNT_W-1:0] o_txn_count
);

    localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [NUM_REQ-1:0] r_grant;
    logic [ID_W-1:0]    r_grant_id;
    logic               r_grant_valid;
    logic               r_cu_request;
    logic               r_rr_sel;
    logic               r_timeout_err;
    logic [ID_W-1:0]    r_ptr;
    logic [WD_W-1:0]    r_wd;
    logic [COUNT_W-1:0] r_busy;
    logic [COUNT_W-1:0] r_txn;

    logic [ID_W-1:0]    w_lo_id;
    logic [ID_W-1:0]    w_hi_id;
    logic               w_hi_found;
    logic [ID_W-1:0]    w_win_id;
    logic [NUM_REQ-1:0] w_win_oh;
    logic               w_start;
    logic               w_done;
    logic               w_timeout;

    // Winner select: descending scan leaves the lowest set index, and the
    // lowest set index at or above the pointer (round-robin without wrap).
    always_comb begin
        w_lo_id    = '0;
        w_hi_id    = '0;
        w_hi_found = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                w_lo_id = ID_W'(i);
                if (ID_W'(i) >= r_ptr) begin
                    w_hi_id    = ID_W'(i);
                    w_hi_found = 1'b1;
                end
            end
        end
        // Nothing at/above the pointer means the search wraps to the lowest index.
        w_win_id = (i_rr_mode && w_hi_found) ? w_hi_id : w_lo_id;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_win_oh[i] = (w_win_id == ID_W'(i));
        end
    end

    // Next-state logic and transition strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_done      = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_enable && (|i_req)) begin
                    w_state_nxt = S_ISSUE;
                    w_start     = 1'b1;
                end
            end
            S_ISSUE: begin
                // An accepted handshake takes precedence over a same-cycle request drop.
                if (r_cu_request && i_cu_ready) begin
                    w_state_nxt = S_WAIT;
                end else if (!(|(i_req & r_grant))) begin
                    w_state_nxt = S_RELEASE;
                end
            end
            S_WAIT: begin
                if (i_cu_done) begin
                    w_state_nxt = S_RELEASE;
                    w_done      = 1'b1;
                end else if (r_wd == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    w_state_nxt = S_RELEASE;
                    w_timeout   = 1'b1;
                end
            end
            S_RELEASE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant, handshake, watchdog, pointer and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant       <= '0;
            r_grant_id    <= '0;
            r_grant_valid <= 1'b0;
            r_cu_request  <= 1'b0;
            r_rr_sel      <= 1'b0;
            r_timeout_err <= 1'b0;
            r_ptr         <= '0;
            r_wd          <= '0;
            r_busy        <= '0;
            r_txn         <= '0;
        end else begin
            if (w_start) begin
                r_grant       <= w_win_oh;
                r_grant_id    <= w_win_id;
                r_grant_valid <= 1'b1;
                r_rr_sel      <= i_rr_mode;
            end else if (r_state == S_RELEASE) begin
                r_grant       <= '0;
                r_grant_id    <= '0;
                r_grant_valid <= 1'b0;
            end

            r_cu_request <= (w_state_nxt == S_ISSUE);
            r_wd         <= (r_state == S_WAIT) ? r_wd + WD_W'(1) : '0;

            // Pointer moves past the winner only for completed round-robin grants.
            if ((w_done || w_timeout) && r_rr_sel) begin
                r_ptr <= (r_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : r_grant_id + ID_W'(1);
            end

            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end else if (i_err_clr) begin
                r_timeout_err <= 1'b0;
            end

            if (i_err_clr) begin
                r_txn <= '0;
            end else if (w_done && (r_txn != '1)) begin
                r_txn <= r_txn + COUNT_W'(1);
            end

            if (i_err_clr) begin
                r_busy <= '0;
            end else if ((r_state != S_IDLE) && (r_busy != '1)) begin
                r_busy <= r_busy + COUNT_W'(1);
            end
        end
    end

    assign o_grant       = r_grant;
    assign o_grant_id    = r_grant_id;
    assign o_grant_valid = r_grant_valid;
    assign o_cu_request  = r_cu_request;
    assign o_timeout_err = r_timeout_err;
    assign o_busy_cycles = r_busy;
    assign o_txn_count   = r_txn;

endmodule

// File: tb/tb_compute_arbiter.sv
// Testbench for compute_arbiter (NUM_REQ=4, TIMEOUT_CYCLES=8). Expected grant
// winners come from a small arbitration model and flow through a scoreboard
// queue; each scenario task checks its own results.
module tb_compute_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned IW = 2;
    localparam int unsigned TO = 8;
    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          rr_mode;
    logic [NR-1:0] req;
    logic [NR-1:0] grant;
    logic [IW-1:0] grant_id;
    logic          grant_valid;
    logic          cu_request;
    logic          cu_ready;
    logic          cu_done;
    logic          timeout_err;
    logic          err_clr;
    logic [CW-1:0] busy_cycles;
    logic [CW-1:0] txn_count;

    int n_cmp = 0;
    int n_err = 0;
    int exp_q[$];
    int tb_ptr = 0;

    compute_arbiter #(
        .NUM_REQ(NR), .ID_W(IW), .TIMEOUT_CYCLES(TO), .COUNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_enable(enable), .i_rr_mode(rr_mode),
        .i_req(req), .o_grant(grant), .o_grant_id(grant_id),
        .o_grant_valid(grant_valid), .o_cu_request(cu_request),
        .i_cu_ready(cu_ready), .i_cu_done(cu_done), .o_timeout_err(timeout_err),
        .i_err_clr(err_clr), .o_busy_cycles(busy_cycles), .o_txn_count(txn_count)
    );

    always #5 clk = ~clk;

    // Reference arbiter: rotate from the pointer (round-robin) or from 0 (fixed).
    function automatic int pick(input logic [NR-1:0] rq, input int ptr, input logic rr);
        int idx;
        logic [NR-1:0] v;
        v = rq;
        for (int k = 0; k < 4; k++) begin
            idx = rr ? (ptr + k) % 4 : k;
            if (v[idx[1:0]]) return idx;
        end
        return -1;
    endfunction

    function automatic int pop_exp();
        if (exp_q.size() == 0) return -1;
        return exp_q.pop_front();
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; enable = 1'b1; rr_mode = 1'b1; req = '0;
        cu_ready = 1'b0; cu_done = 1'b0; err_clr = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tb_ptr = 0;
        tick();
    endtask

    task automatic wait_valid(input int budget, output bit ok, output int cyc);
        ok = 1'b0; cyc = 0;
        while (cyc < budget && !ok) begin
            tick(); cyc++;
            if (grant_valid === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok, output int cyc);
        ok = 1'b0; cyc = 0;
        while (cyc < budget && !ok) begin
            tick(); cyc++;
            if (grant_valid === 1'b0) ok = 1'b1;
        end
    endtask

    // One transaction with the caller holding cu_ready/cu_done as needed.
    task automatic run_txn(output bit ok, output int cyc, output logic [NR-1:0] g,
                           output logic [IW-1:0] id);
        bit ok1, ok2;
        int c1, c2;
        wait_valid(12, ok1, c1);
        g = grant; id = grant_id;
        wait_idle(20, ok2, c2);
        ok = ok1 && ok2; cyc = c1 + c2;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (grant !== '0 || grant_id !== '0 || grant_valid !== 1'b0 || cu_request !== 1'b0 ||
            timeout_err !== 1'b0 || busy_cycles !== '0 || txn_count !== '0) begin
            n_err++;
            $display("FAIL reset_state: grant=%b id=%0d valid=%b cureq=%b terr=%b busy=%0d txn=%0d, required all zero",
                     grant, grant_id, grant_valid, cu_request, timeout_err, busy_cycles, txn_count);
        end
    endtask

    task automatic test_single();
        int exp, hi;
        do_reset();
        cu_ready = 1'b1; cu_done = 1'b0;
        req = 4'b0100;
        exp_q.push_back(pick(req, tb_ptr, 1'b1));
        tick();
        exp = pop_exp();
        n_cmp++;
        if (grant_valid !== 1'b1 || grant !== 4'b0100 || grant_id !== 2'(exp)) begin
            n_err++;
            $display("FAIL single_grant: valid=%b grant=%b id=%0d, required 1 0100 %0d",
                     grant_valid, grant, grant_id, exp);
        end
        hi = (cu_request === 1'b1) ? 1 : 0;
        repeat (3) begin
            tick();
            if (cu_request === 1'b1) hi++;
        end
        cu_done = 1'b1;
        tick();
        cu_done = 1'b0; req = '0;
        n_cmp++;
        if (grant_valid !== 1'b1 || txn_count !== 16'd1) begin
            n_err++;
            $display("FAIL single_release: valid=%b txn=%0d, required 1 1", grant_valid, txn_count);
        end
        tick();
        n_cmp++;
        if (grant !== '0 || grant_valid !== 1'b0 || grant_id !== '0) begin
            n_err++;
            $display("FAIL single_clear: grant=%b valid=%b id=%0d, required 0 0 0",
                     grant, grant_valid, grant_id);
        end
        n_cmp++;
        if (hi != 1) begin
            n_err++;
            $display("FAIL single_cureq_len: %0d cycles high, required 1", hi);
        end
        n_cmp++;
        if (busy_cycles !== 16'd5) begin
            n_err++;
            $display("FAIL single_busy: got %0d, required 5", busy_cycles);
        end
        tb_ptr = (exp + 1) % 4;
    endtask

    task automatic test_round_robin();
        bit ok; int c, exp;
        logic [NR-1:0] g, exp_oh;
        logic [IW-1:0] id;
        do_reset();
        cu_ready = 1'b1; cu_done = 1'b1; req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_q.push_back(pick(req, tb_ptr, 1'b1));
            run_txn(ok, c, g, id);
            if (k == 4) req = '0;
            exp = pop_exp();
            exp_oh = 4'b0001 << exp;
            n_cmp++;
            if (!ok || id !== 2'(exp) || g !== exp_oh || c != 4) begin
                n_err++;
                $display("FAIL rr_grant%0d: ok=%b id=%0d grant=%b cycles=%0d, required id %0d grant %b cycles 4",
                         k, ok, id, g, c, exp, exp_oh);
            end
            tb_ptr = (exp + 1) % 4;
        end
        n_cmp++;
        if (busy_cycles !== 16'd15 || txn_count !== 16'd5) begin
            n_err++;
            $display("FAIL rr_counters: busy=%0d txn=%0d, required 15 5", busy_cycles, txn_count);
        end
    endtask

    task automatic test_fixed_priority();
        bit ok; int c, exp;
        logic [NR-1:0] g;
        logic [IW-1:0] id;
        do_reset();
        cu_ready = 1'b1; cu_done = 1'b1; rr_mode = 1'b1; req = 4'b0010;
        exp_q.push_back(pick(req, tb_ptr, 1'b1));
        run_txn(ok, c, g, id);
        exp = pop_exp();
        tb_ptr = (exp + 1) % 4;
        req = 4'b1010; rr_mode = 1'b0;
        n_cmp++;
        if (!ok || id !== 2'(exp)) begin
            n_err++;
            $display("FAIL fp_setup: ok=%b id=%0d, required %0d", ok, id, exp);
        end
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(pick(req, tb_ptr, 1'b0));
            run_txn(ok, c, g, id);
            exp = pop_exp();
            n_cmp++;
            if (!ok || id !== 2'(exp) || g[3] !== 1'b0) begin
                n_err++;
                $display("FAIL fp_grant%0d: ok=%b id=%0d grant=%b, required id %0d", k, ok, id, g, exp);
            end
        end
        rr_mode = 1'b1;
        exp_q.push_back(pick(req, tb_ptr, 1'b1));
        run_txn(ok, c, g, id);
        req = '0;
        exp = pop_exp();
        tb_ptr = (exp + 1) % 4;
        n_cmp++;
        if (!ok || id !== 2'(exp)) begin
            n_err++;
            $display("FAIL fp_to_rr: ok=%b id=%0d, required %0d", ok, id, exp);
        end
    endtask

    task automatic test_watchdog();
        bit ok; int c, exp, wc;
        logic [NR-1:0] g;
        logic [IW-1:0] id;
        do_reset();
        cu_ready = 1'b1; cu_done = 1'b0; req = 4'b0100;
        exp_q.push_back(pick(req, tb_ptr, 1'b1));
        wait_valid(8, ok, c);
        exp = pop_exp();
        n_cmp++;
        if (!ok || grant_id !== 2'(exp)) begin
            n_err++;
            $display("FAIL wd_grant: ok=%b id=%0d, required %0d", ok, grant_id, exp);
        end
        wc = 0;
        for (int i = 0; i < 40 && timeout_err !== 1'b1; i++) begin
            tick();
            if (timeout_err !== 1'b1 && grant_valid === 1'b1 && cu_request === 1'b0) wc++;
        end
        req = '0;
        n_cmp++;
        if (wc != int'(TO) || timeout_err !== 1'b1 || txn_count !== '0 || grant_valid !== 1'b1) begin
            n_err++;
            $display("FAIL wd_timeout: wait=%0d terr=%b txn=%0d valid=%b, required %0d 1 0 1",
                     wc, timeout_err, txn_count, grant_valid, TO);
        end
        tb_ptr = (exp + 1) % 4;
        tick();
        n_cmp++;
        if (grant_valid !== 1'b0 || busy_cycles !== 16'd10 || timeout_err !== 1'b1) begin
            n_err++;
            $display("FAIL wd_release: valid=%b busy=%0d terr=%b, required 0 10 1",
                     grant_valid, busy_cycles, timeout_err);
        end
        cu_done = 1'b1; req = 4'b1001;
        exp_q.push_back(pick(req, tb_ptr, 1'b1));
        run_txn(ok, c, g, id);
        req = '0;
        exp = pop_exp();
        tb_ptr = (exp + 1) % 4;
        n_cmp++;
        if (!ok || id !== 2'(exp) || txn_count !== 16'd1) begin
            n_err++;
            $display("FAIL wd_ptr_advanced: ok=%b id=%0d txn=%0d, required id %0d txn 1",
                     ok, id, txn_count, exp);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_cmp++;
        if (timeout_err !== 1'b0 || busy_cycles !== '0 || txn_count !== '0) begin
            n_err++;
            $display("FAIL wd_err_clr: terr=%b busy=%0d txn=%0d, required 0 0 0",
                     timeout_err, busy_cycles, txn_count);
        end
    endtask

    task automatic test_abort_gating();
        bit ok, seen; int c, exp;
        logic [NR-1:0] g;
        logic [IW-1:0] id;
        do_reset();
        cu_ready = 1'b0; cu_done = 1'b0; req = 4'b0010;
        exp_q.push_back(pick(req, tb_ptr, 1'b1));
        wait_valid(8, ok, c);
        exp = pop_exp();
        tick();
        n_cmp++;
        if (!ok || grant_id !== 2'(exp) || cu_request !== 1'b1) begin
            n_err++;
            $display("FAIL abort_issue: ok=%b id=%0d cureq=%b, required id %0d cureq 1",
                     ok, grant_id, cu_request, exp);
        end
        req = '0;
        wait_idle(6, ok, c);
        n_cmp++;
        if (!ok || txn_count !== '0 || cu_request !== 1'b0) begin
            n_err++;
            $display("FAIL abort_release: ok=%b txn=%0d cureq=%b, required 1 0 0",
                     ok, txn_count, cu_request);
        end
        cu_ready = 1'b1; cu_done = 1'b1; req = 4'b0110;
        exp_q.push_back(pick(req, tb_ptr, 1'b1));
        run_txn(ok, c, g, id);
        req = '0;
        exp = pop_exp();
        tb_ptr = (exp + 1) % 4;
        n_cmp++;
        if (!ok || id !== 2'(exp)) begin
            n_err++;
            $display("FAIL abort_ptr_kept: ok=%b id=%0d, required %0d", ok, id, exp);
        end
        enable = 1'b0; req = 4'b0001; seen = 1'b0;
        repeat (5) begin
            tick();
            if (grant_valid !== 1'b0) seen = 1'b1;
        end
        n_cmp++;
        if (seen) begin
            n_err++;
            $display("FAIL gate_no_grant: grant seen while disabled, required none");
        end
        enable = 1'b1;
        exp_q.push_back(pick(req, tb_ptr, 1'b1));
        run_txn(ok, c, g, id);
        req = '0;
        exp = pop_exp();
        tb_ptr = (exp + 1) % 4;
        n_cmp++;
        if (!ok || id !== 2'(exp) || c != 4) begin
            n_err++;
            $display("FAIL gate_enable: ok=%b id=%0d cycles=%0d, required id %0d cycles 4",
                     ok, id, c, exp);
        end
    endtask

    task automatic test_reset_mid_txn();
        bit ok; int c, exp;
        logic [NR-1:0] g;
        logic [IW-1:0] id;
        cu_ready = 1'b1; cu_done = 1'b0; req = 4'b0001;
        exp_q.push_back(pick(req, tb_ptr, 1'b1));
        wait_valid(8, ok, c);
        exp = pop_exp();
        tick();
        n_cmp++;
        if (!ok || grant_id !== 2'(exp) || grant_valid !== 1'b1 || cu_request !== 1'b0) begin
            n_err++;
            $display("FAIL rst_wait_setup: ok=%b id=%0d valid=%b cureq=%b, required id %0d valid 1 cureq 0",
                     ok, grant_id, grant_valid, cu_request, exp);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (grant !== '0 || grant_valid !== 1'b0 || cu_request !== 1'b0 || grant_id !== '0) begin
            n_err++;
            $display("FAIL rst_mid_wait: grant=%b valid=%b cureq=%b id=%0d, required all zero",
                     grant, grant_valid, cu_request, grant_id);
        end
        tick();
        rst_n = 1'b1; tb_ptr = 0; cu_ready = 1'b0; req = 4'b1111;
        exp_q.push_back(pick(req, tb_ptr, 1'b1));
        wait_valid(8, ok, c);
        exp = pop_exp();
        n_cmp++;
        if (!ok || grant_id !== 2'(exp) || cu_request !== 1'b1) begin
            n_err++;
            $display("FAIL rst_ptr_zero: ok=%b id=%0d cureq=%b, required id %0d cureq 1",
                     ok, grant_id, cu_request, exp);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (cu_request !== 1'b0 || grant_valid !== 1'b0 || grant !== '0) begin
            n_err++;
            $display("FAIL rst_mid_issue: cureq=%b valid=%b grant=%b, required 0 0 0",
                     cu_request, grant_valid, grant);
        end
        tick();
        rst_n = 1'b1; tb_ptr = 0; cu_ready = 1'b1; cu_done = 1'b1; req = 4'b1110;
        exp_q.push_back(pick(req, tb_ptr, 1'b1));
        run_txn(ok, c, g, id);
        req = '0;
        exp = pop_exp();
        n_cmp++;
        if (!ok || id !== 2'(exp)) begin
            n_err++;
            $display("FAIL rst_recover: ok=%b id=%0d, required %0d", ok, id, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b1; rr_mode = 1'b1; req = '0;
        cu_ready = 1'b0; cu_done = 1'b0; err_clr = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_fixed_priority();
        test_watchdog();
        test_abort_gating();
        test_reset_mid_txn();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "time limit");
    end

endmodule
